// File: rtl/video_scanout.sv
// Raster scanout: h/v timing, registered syncs, priority layer compositing,
// scanline prefetch strobes and a sticky vblank interrupt.
module video_scanout #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 2,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int X_OFFSET   = 31,
    parameter int DISP_W     = 256,
    parameter int DISP_H     = 240,
    parameter logic [3*COLOR_W-1:0] BACKDROP = '0,
    parameter bit IRQ_BOTH_EDGES = 1'b1
) (
    input  logic                           gpu_clk,
    input  logic                           rst_n,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb_i,
    input  logic [NUM_LAYERS-1:0]          layer_valid_i,
    input  logic [NUM_LAYERS-1:0]          layer_en_i,
    input  logic                           irq_clr_i,
    output logic [COLOR_W-1:0]             r_o,
    output logic [COLOR_W-1:0]             g_o,
    output logic [COLOR_W-1:0]             b_o,
    output logic                           hsync_o,
    output logic                           vsync_o,
    output logic [7:0]                     x_o,
    output logic [7:0]                     y_o,
    output logic                           drawing_o,
    output logic                           prefetch_start_o,
    output logic [7:0]                     prefetch_y_o,
    output logic                           in_vblank_o,
    output logic                           vblank_irq_o,
    output logic [7:0]                     frame_cnt_o
);

    localparam int PW    = 3 * COLOR_W;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    // Counters are at least 9 bits wide so the x/y slices always exist.
    localparam int HW = ($clog2(H_TOT) > 9) ? $clog2(H_TOT) : 9;
    localparam int VW = ($clog2(V_TOT) > 9) ? $clog2(V_TOT) : 9;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VISW = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VISW = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VW-1:0] PF_LIM = VW'(V_VIS - 2);
    localparam logic [8:0]    X_OFF9 = 9'(X_OFFSET);
    localparam logic [9:0]    DISP_W10 = 10'(DISP_W);
    localparam logic [8:0]    DISP_H9  = 9'(DISP_H);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [7:0]    frame_q, frame_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          irq_q, irq_d;
    logic          vb_hist_q, vb_hist_d;

    logic          visible;
    logic          drawing;
    logic          in_vb;
    logic          vb_edge;
    logic          hit;
    logic [8:0]    x9;

    always_comb begin
        h_d       = h_q + HW'(1);
        v_d       = v_q;
        frame_d   = frame_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d     = '0;
                frame_d = frame_q + 8'd1;
            end else begin
                v_d = v_q + VW'(1);
            end
        end

        visible = (h_q < H_VISW) && (v_q < V_VISW);
        x9      = h_q[8:0] - X_OFF9;
        drawing = visible && ({1'b0, x9} < DISP_W10) && ({1'b0, v_q[8:1]} < DISP_H9);

        hsync_d = !((h_q >= HS_BEG) && (h_q < HS_END));
        vsync_d = !((v_q >= VS_BEG) && (v_q < VS_END));

        // Walk layers upward; the first enabled opaque one wins.
        pix_d = BACKDROP;
        hit   = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (!hit && layer_en_i[i] && layer_valid_i[i]) begin
                pix_d = layer_rgb_i[i*PW +: PW];
                hit   = 1'b1;
            end
        end
        if (!drawing) pix_d = '0;

        in_vb     = (v_q >= V_VISW);
        vb_hist_d = in_vb;
        vb_edge   = IRQ_BOTH_EDGES ? (in_vb ^ vb_hist_q) : (in_vb & ~vb_hist_q);
        // A clear in the same cycle as an edge swallows that edge.
        if (irq_clr_i)    irq_d = 1'b0;
        else if (vb_edge) irq_d = 1'b1;
        else              irq_d = irq_q;
    end

    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            frame_q   <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            pix_q     <= '0;
            irq_q     <= 1'b1;
            vb_hist_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            frame_q   <= frame_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            pix_q     <= pix_d;
            irq_q     <= irq_d;
            vb_hist_q <= vb_hist_d;
        end
    end

    assign r_o          = pix_q[3*COLOR_W-1:2*COLOR_W];
    assign g_o          = pix_q[2*COLOR_W-1:COLOR_W];
    assign b_o          = pix_q[COLOR_W-1:0];
    assign hsync_o      = hsync_q;
    assign vsync_o      = vsync_q;
    assign x_o          = x9[7:0];
    assign y_o          = v_q[8:1];
    assign drawing_o    = drawing;
    assign in_vblank_o  = in_vb;
    assign vblank_irq_o = irq_q;
    assign frame_cnt_o  = frame_q;

    // The last line of the frame fetches display line 0; even visible lines fetch the next one.
    assign prefetch_start_o = (h_q == '0) &&
                              ((v_q == V_LAST) || (!v_q[0] && (v_q < PF_LIM)));
    assign prefetch_y_o     = (v_q == V_LAST) ? 8'd0 : (v_q[8:1] + 8'd1);

endmodule

// File: tb/tb_video_scanout.sv
// Directed bench for video_scanout on scaled raster timing (400 x 22 totals)
// so several full frames fit in a short run.
module tb_video_scanout;

    localparam int NL = 4, CW = 2;
    localparam int HV = 320, HF = 8, HS = 48, HB = 24;
    localparam int VV = 16, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic gpu_clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NL*3*CW-1:0] layer_rgb;
    logic [NL-1:0] layer_valid, layer_en;
    logic clr_a, clr_b;

    logic [CW-1:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic hsync_a, vsync_a, draw_a, pfs_a, invb_a, irq_a;
    logic hsync_b, vsync_b, draw_b, pfs_b, invb_b, irq_b;
    logic [7:0] x_a, y_a, pfy_a, frm_a, x_b, y_b, pfy_b, frm_b;
    wire  [5:0] rgb_a = {r_a, g_a, b_a};

    int checks = 0, failures = 0;
    int tb_h, tb_v;

    always #5 gpu_clk = ~gpu_clk;

    video_scanout #(.NUM_LAYERS(NL), .COLOR_W(CW), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .IRQ_BOTH_EDGES(1'b1)) u_dut (
        .gpu_clk(gpu_clk), .rst_n(rst_n), .layer_rgb_i(layer_rgb), .layer_valid_i(layer_valid),
        .layer_en_i(layer_en), .irq_clr_i(clr_a), .r_o(r_a), .g_o(g_a), .b_o(b_a),
        .hsync_o(hsync_a), .vsync_o(vsync_a), .x_o(x_a), .y_o(y_a), .drawing_o(draw_a),
        .prefetch_start_o(pfs_a), .prefetch_y_o(pfy_a), .in_vblank_o(invb_a),
        .vblank_irq_o(irq_a), .frame_cnt_o(frm_a));

    video_scanout #(.NUM_LAYERS(NL), .COLOR_W(CW), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .IRQ_BOTH_EDGES(1'b0)) u_dut_rise (
        .gpu_clk(gpu_clk), .rst_n(rst_n), .layer_rgb_i(layer_rgb), .layer_valid_i(layer_valid),
        .layer_en_i(layer_en), .irq_clr_i(clr_b), .r_o(r_b), .g_o(g_b), .b_o(b_b),
        .hsync_o(hsync_b), .vsync_o(vsync_b), .x_o(x_b), .y_o(y_b), .drawing_o(draw_b),
        .prefetch_start_o(pfs_b), .prefetch_y_o(pfy_b), .in_vblank_o(invb_b),
        .vblank_irq_o(irq_b), .frame_cnt_o(frm_b));

    // Reference raster position, advanced on the same edges as the DUT.
    always @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_h <= 0;
            tb_v <= 0;
        end else if (tb_h == HT - 1) begin
            tb_h <= 0;
            tb_v <= (tb_v == VT - 1) ? 0 : tb_v + 1;
        end else begin
            tb_h <= tb_h + 1;
        end
    end

    task automatic goto(input int th, input int tv);
        int n = 0;
        @(negedge gpu_clk);
        while (!(tb_h == th && tb_v == tv) && n < 20000) begin
            @(negedge gpu_clk);
            n++;
        end
        if (!(tb_h == th && tb_v == tv)) begin
            checks++; failures++;
            $display("FAIL goto_timeout at h=%0d v=%0d wanted h=%0d v=%0d", tb_h, tb_v, th, tv);
        end
    endtask

    task automatic test_reset();
        layer_rgb = '0; layer_valid = '0; layer_en = '0; clr_a = 0; clr_b = 0;
        rst_n = 0;
        repeat (3) @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b0) begin failures++; $display("FAIL rst_rgb got=%b exp=000000", rgb_a); end
        checks++; if (hsync_a !== 1'b1) begin failures++; $display("FAIL rst_hsync got=%b exp=1", hsync_a); end
        checks++; if (vsync_a !== 1'b1) begin failures++; $display("FAIL rst_vsync got=%b exp=1", vsync_a); end
        checks++; if (irq_a !== 1'b1) begin failures++; $display("FAIL rst_irq got=%b exp=1", irq_a); end
        checks++; if (frm_a !== 8'd0) begin failures++; $display("FAIL rst_frame got=%0d exp=0", frm_a); end
        checks++; if (x_a !== 8'd225) begin failures++; $display("FAIL rst_x got=%0d exp=225", x_a); end
        checks++; if (y_a !== 8'd0) begin failures++; $display("FAIL rst_y got=%0d exp=0", y_a); end
        checks++; if (draw_a !== 1'b0) begin failures++; $display("FAIL rst_drawing got=%b exp=0", draw_a); end
        checks++; if (invb_a !== 1'b0) begin failures++; $display("FAIL rst_invb got=%b exp=0", invb_a); end
        checks++; if (pfs_a !== 1'b1 || pfy_a !== 8'd1) begin failures++;
            $display("FAIL rst_prefetch got=%b/%0d exp=1/1", pfs_a, pfy_a); end
        rst_n = 1;
        @(negedge gpu_clk);
        checks++; if (x_a !== 8'd226) begin failures++; $display("FAIL resume_x got=%0d exp=226", x_a); end
    endtask

    task automatic test_timing();
        int low = 0;
        goto(HV + HF, 0);
        checks++; if (hsync_a !== 1'b1) begin failures++; $display("FAIL hs_pre got=%b exp=1", hsync_a); end
        @(negedge gpu_clk);
        checks++; if (hsync_a !== 1'b0) begin failures++; $display("FAIL hs_start got=%b exp=0", hsync_a); end
        goto(HV + HF + HS, 0);
        checks++; if (hsync_a !== 1'b0) begin failures++; $display("FAIL hs_last got=%b exp=0", hsync_a); end
        @(negedge gpu_clk);
        checks++; if (hsync_a !== 1'b1) begin failures++; $display("FAIL hs_end got=%b exp=1", hsync_a); end
        goto(0, 1);
        for (int i = 0; i < HT; i++) begin
            if (hsync_a === 1'b0) low++;
            @(negedge gpu_clk);
        end
        checks++; if (low != HS) begin failures++; $display("FAIL hs_width got=%0d exp=%0d", low, HS); end
        goto(0, 18);
        checks++; if (vsync_a !== 1'b1) begin failures++; $display("FAIL vs_pre got=%b exp=1", vsync_a); end
        goto(1, 18);
        checks++; if (vsync_a !== 1'b0) begin failures++; $display("FAIL vs_start got=%b exp=0", vsync_a); end
        goto(0, 20);
        checks++; if (vsync_a !== 1'b0) begin failures++; $display("FAIL vs_last got=%b exp=0", vsync_a); end
        goto(1, 20);
        checks++; if (vsync_a !== 1'b1) begin failures++; $display("FAIL vs_end got=%b exp=1", vsync_a); end
        goto(0, 0);
        checks++; if (frm_a !== 8'd1) begin failures++; $display("FAIL frame1 got=%0d exp=1", frm_a); end
        goto(0, 0);
        checks++; if (frm_a !== 8'd2) begin failures++; $display("FAIL frame2 got=%0d exp=2", frm_a); end
    endtask

    task automatic test_compose();
        layer_rgb = {6'b101010, 6'b010101, 6'b001111, 6'b110000};
        goto(31, 0);
        checks++; if (x_a !== 8'd0 || draw_a !== 1'b1) begin failures++;
            $display("FAIL cmp_x0 got=%0d/%b exp=0/1", x_a, draw_a); end
        layer_en = 4'b1111; layer_valid = 4'b0011;
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b110000) begin failures++; $display("FAIL cmp_l0 got=%b exp=110000", rgb_a); end
        layer_en = 4'b1110; layer_valid = 4'b0001;
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b000000) begin failures++; $display("FAIL cmp_backdrop got=%b exp=000000", rgb_a); end
        layer_valid = 4'b0011;
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b001111) begin failures++; $display("FAIL cmp_l1 got=%b exp=001111", rgb_a); end
        layer_en = 4'b1111; layer_valid = 4'b1100;
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b010101) begin failures++; $display("FAIL cmp_l2 got=%b exp=010101", rgb_a); end
        layer_valid = 4'b1000;
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b101010) begin failures++; $display("FAIL cmp_l3 got=%b exp=101010", rgb_a); end
        layer_valid = 4'b1111;
        goto(300, 0);
        checks++; if (x_a !== 8'd13 || draw_a !== 1'b0) begin failures++;
            $display("FAIL cmp_x269 got=%0d/%b exp=13/0", x_a, draw_a); end
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b0) begin failures++; $display("FAIL cmp_offscreen got=%b exp=000000", rgb_a); end
        goto(286, 1);
        checks++; if (x_a !== 8'd255 || draw_a !== 1'b1) begin failures++;
            $display("FAIL cmp_x255 got=%0d/%b exp=255/1", x_a, draw_a); end
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b110000 || draw_a !== 1'b0) begin failures++;
            $display("FAIL cmp_right_edge got=%b/%b exp=110000/0", rgb_a, draw_a); end
        goto(30, 2);
        checks++; if (x_a !== 8'd255 || draw_a !== 1'b0) begin failures++;
            $display("FAIL cmp_left_pre got=%0d/%b exp=255/0", x_a, draw_a); end
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b0 || draw_a !== 1'b1) begin failures++;
            $display("FAIL cmp_left_edge got=%b/%b exp=000000/1", rgb_a, draw_a); end
        @(negedge gpu_clk);
        checks++; if (rgb_a !== 6'b110000) begin failures++; $display("FAIL cmp_left_first got=%b exp=110000", rgb_a); end
        goto(100, 5);
        checks++; if (y_a !== 8'd2) begin failures++; $display("FAIL cmp_y got=%0d exp=2", y_a); end
        layer_valid = '0; layer_en = '0;
    endtask

    task automatic test_prefetch();
        goto(0, 10);
        checks++; if (pfs_a !== 1'b1 || pfy_a !== 8'd6) begin failures++;
            $display("FAIL pf_v10 got=%b/%0d exp=1/6", pfs_a, pfy_a); end
        goto(1, 10);
        checks++; if (pfs_a !== 1'b0) begin failures++; $display("FAIL pf_h1 got=%b exp=0", pfs_a); end
        goto(0, 11);
        checks++; if (pfs_a !== 1'b0) begin failures++; $display("FAIL pf_v11 got=%b exp=0", pfs_a); end
        goto(0, 12);
        checks++; if (pfs_a !== 1'b1 || pfy_a !== 8'd7) begin failures++;
            $display("FAIL pf_v12 got=%b/%0d exp=1/7", pfs_a, pfy_a); end
        goto(0, VV - 2);
        checks++; if (pfs_a !== 1'b0) begin failures++; $display("FAIL pf_vlim got=%b exp=0", pfs_a); end
        goto(0, VT - 1);
        checks++; if (pfs_a !== 1'b1 || pfy_a !== 8'd0) begin failures++;
            $display("FAIL pf_vlast got=%b/%0d exp=1/0", pfs_a, pfy_a); end
    endtask

    task automatic test_irq();
        goto(0, 1);
        clr_a = 1; clr_b = 1;
        @(negedge gpu_clk);
        clr_a = 0; clr_b = 0;
        checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin failures++;
            $display("FAIL irq_clear got=%b/%b exp=0/0", irq_a, irq_b); end
        goto(HT - 1, VV - 1);
        checks++; if (invb_a !== 1'b0) begin failures++; $display("FAIL invb_last_vis got=%b exp=0", invb_a); end
        goto(0, VV);
        checks++; if (invb_a !== 1'b1 || irq_a !== 1'b0) begin failures++;
            $display("FAIL invb_first got=%b/%b exp=1/0", invb_a, irq_a); end
        @(negedge gpu_clk);
        checks++; if (irq_a !== 1'b1 || irq_b !== 1'b1) begin failures++;
            $display("FAIL irq_rise got=%b/%b exp=1/1", irq_a, irq_b); end
        goto(0, VV + 1);
        clr_a = 1; clr_b = 1;
        @(negedge gpu_clk);
        clr_a = 0; clr_b = 0;
        goto(1, 0);
        checks++; if (irq_a !== 1'b1 || irq_b !== 1'b0) begin failures++;
            $display("FAIL irq_fall got=%b/%b exp=1/0", irq_a, irq_b); end
        goto(0, 5);
        checks++; if (irq_a !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq_a); end
        clr_a = 1;
        @(negedge gpu_clk);
        clr_a = 0;
        checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_clear2 got=%b exp=0", irq_a); end
        goto(1, VV);
        checks++; if (irq_a !== 1'b1 || irq_b !== 1'b1) begin failures++;
            $display("FAIL irq_rise2 got=%b/%b exp=1/1", irq_a, irq_b); end
        goto(0, VV + 1);
        clr_a = 1; clr_b = 1;
        @(negedge gpu_clk);
        clr_b = 0;
        goto(HT - 1, VT - 1);
        @(negedge gpu_clk);
        @(negedge gpu_clk);
        clr_a = 0;
        checks++; if (irq_a !== 1'b0 || irq_b !== 1'b0) begin failures++;
            $display("FAIL irq_clr_wins got=%b/%b exp=0/0", irq_a, irq_b); end
        goto(5, 0);
        checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL irq_lost_edge got=%b exp=0", irq_a); end
    endtask

    task automatic test_reset_mid();
        goto(340, 18);
        checks++; if (hsync_a !== 1'b0 || vsync_a !== 1'b0 || frm_a !== 8'd5) begin failures++;
            $display("FAIL mid_pre got=%b/%b/%0d exp=0/0/5", hsync_a, vsync_a, frm_a); end
        clr_a = 1;
        @(negedge gpu_clk);
        clr_a = 0;
        checks++; if (irq_a !== 1'b0) begin failures++; $display("FAIL mid_clear got=%b exp=0", irq_a); end
        #2 rst_n = 0;
        #1;
        checks++; if (hsync_a !== 1'b1 || vsync_a !== 1'b1) begin failures++;
            $display("FAIL mid_syncs got=%b/%b exp=1/1", hsync_a, vsync_a); end
        checks++; if (irq_a !== 1'b1 || frm_a !== 8'd0 || rgb_a !== 6'b0) begin failures++;
            $display("FAIL mid_regs got=%b/%0d/%b exp=1/0/000000", irq_a, frm_a, rgb_a); end
        checks++; if (x_a !== 8'd225 || y_a !== 8'd0 || invb_a !== 1'b0) begin failures++;
            $display("FAIL mid_pos got=%0d/%0d/%b exp=225/0/0", x_a, y_a, invb_a); end
        repeat (3) @(negedge gpu_clk);
        rst_n = 1;
        @(negedge gpu_clk);
        checks++; if (x_a !== 8'd226 || irq_a !== 1'b1) begin failures++;
            $display("FAIL mid_resume got=%0d/%b exp=226/1", x_a, irq_a); end
        clr_a = 1;
        @(negedge gpu_clk);
        clr_a = 0;
        repeat (10) @(negedge gpu_clk);
        checks++; if (irq_a !== 1'b0 || y_a !== 8'd0) begin failures++;
            $display("FAIL mid_no_spurious got=%b/%0d exp=0/0", irq_a, y_a); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_compose();
        test_prefetch();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_scanout.md
VIDEO_SCANOUT -- requirements
Module: video_scanout

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of compositing layers; index 0 is highest priority.
REQ-002 SHALL have parameter COLOR_W, default 2, bits per colour channel.
REQ-003 SHALL have parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in clocks.
REQ-004 SHALL have parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-005 SHALL have parameters X_OFFSET 31, DISP_W 256, DISP_H 240, BACKDROP 0 (3*COLOR_W bits), IRQ_BOTH_EDGES 1.
REQ-006 SHALL have ports: gpu_clk  in  1  pixel clock; rst_n  in  1  reset.
REQ-007 SHALL have ports: layer_rgb_i  in  NUM_LAYERS*3*COLOR_W  {r,g,b} per layer, layer 0 in LSBs; layer_valid_i  in  NUM_LAYERS  opaque flags; layer_en_i  in  NUM_LAYERS  layer enables.
REQ-008 SHALL have ports: irq_clr_i  in  1  clear vblank IRQ; r_o/g_o/b_o  out  COLOR_W each; hsync_o, vsync_o  out  1  active-low syncs.
REQ-009 SHALL have ports: x_o  out  8  display x; y_o  out  8  display y; drawing_o  out  1; prefetch_start_o  out  1; prefetch_y_o  out  8; in_vblank_o  out  1; vblank_irq_o  out  1; frame_cnt_o  out  8.
REQ-010 SHALL use one clock and an asynchronous, active-low reset: gpu_clk and rst_n.

Function
REQ-011 SHALL count h from 0 to H_TOT-1 (H_TOT = sum of H params), wrapping to 0 and incrementing v; v wraps at V_TOT-1 to 0.
REQ-012 SHALL increment frame_cnt_o modulo 256 on the cycle h and v both wrap.
REQ-013 SHALL define visible = (h < H_VIS) && (v < V_VIS); in_vblank_o = (v >= V_VIS), combinational from counters.
REQ-014 SHALL derive hsync_o low iff H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC, vsync_o low likewise on v, both registered (1-cycle latency).
REQ-015 SHALL drive x_o = (h[8:0] - X_OFFSET) mod 512, truncated to 8 bits, and y_o = v[8:1], combinationally; drawing_o = visible && 9-bit x < DISP_W && y < DISP_H.
REQ-016 SHALL treat layer inputs as combinationally valid for the current x_o/y_o.
REQ-017 SHALL select the lowest-index layer with layer_en_i and layer_valid_i both set; if none, BACKDROP; if not drawing, all-zero.
REQ-018 SHALL register the selected colour into r_o/g_o/b_o: 1-cycle latency, aligned with hsync_o/vsync_o.
REQ-019 SHALL pulse prefetch_start_o for one cycle when h == 0 and v == V_TOT-1, with prefetch_y_o = 0.
REQ-020 SHALL pulse prefetch_start_o when h == 0, v even and v < V_VIS-2, with prefetch_y_o = v/2 + 1; prefetch_y_o is don't-care otherwise.
REQ-021 SHALL set vblank_irq_o on any in_vblank_o change if IRQ_BOTH_EDGES = 1, else on its rising edge only.
REQ-022 SHALL give irq_clr_i priority over a same-cycle set: the IRQ clears and that edge is lost.
REQ-023 SHALL hold vblank_irq_o until irq_clr_i; repeated edges while set have no extra effect.

Reset
REQ-024 SHALL on rst_n low asynchronously clear h, v and frame_cnt_o and drive r_o/g_o/b_o to 0, hsync_o/vsync_o to 1, and vblank_irq_o to 1 (pending after reset).
REQ-025 SHALL clear the internal in_vblank history to 0 on reset.
REQ-026 SHALL on reset mid-frame restart at h = v = 0 with no spurious IRQ edge on the first post-reset cycle.
REQ-027 SHALL resume counting on the first gpu_clk edge after rst_n deasserts.

Verification
REQ-028 Defaults, run 2 frames -> hsync_o low for 96 clocks starting 1 cycle after h = 656; vsync_o low during lines 490-491; frame_cnt_o = 2.
REQ-029 h = 31, v = 0, layer 0 valid and enabled with rgb 6'b110000, layer 1 valid -> next-cycle {r,g,b} = 6'b110000.
REQ-030 layer_en_i = 4'b1110, only layer 0 valid -> BACKDROP 0 output; at h = 300 (x = 269) -> 0.
REQ-031 h = 0, v = 10 -> prefetch_start_o = 1 and prefetch_y_o = 6; v = 11 -> 0; v = 524 -> 1 and prefetch_y_o = 0; v = 478 -> 0.
REQ-032 After clear, v reaches 480 -> vblank_irq_o = 1; irq_clr_i in the same cycle as v wraps to 0 -> vblank_irq_o = 0; IRQ_BOTH_EDGES = 0 -> no set at wrap.
REQ-033 Assert rst_n low at v = 200 -> outputs take reset values immediately without a clock; after release h, v count from 0 and vblank_irq_o = 1.
